axil_register_responder: RTL and testbench
==========================================

# axil_register_responder

AXI-Lite responder (slave end of the codebase's `axi_lite` interface) that exposes a bank of 32-bit control/status registers to the processing system. It accepts independent write-address, write-data and read-address transactions and applies byte strobes. Control registers drive fabric logic, status registers sample fabric inputs, and a per-register write pulse notifies downstream logic. It sits behind the interconnect in every peripheral that needs a memory-mapped register map.

## Interface
- `N_REGISTERS`, 8: number of 32-bit registers (1..64).
- `BASE_ADDRESS`, 32'h0: byte address of register 0; must be 4-byte aligned.
- `RO_MASK`, 0: N_REGISTERS-bit mask; bit i set means register i is read-only (status).
- `clock`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `axil`  `axi_lite.slave`  DATA_WIDTH=32, ADDR_WIDTH=32  bus responder port.
- `input_registers`  in  N_REGISTERS×32  status values returned for RO registers.
- `output_registers`  out  N_REGISTERS×32  current value of RW registers; RO entries read 0.
- `register_write_pulse`  out  N_REGISTERS  one-cycle pulse on each committed write to register i.

## Operation
- Decode: index = (ADDR − BASE_ADDRESS) >> 2; ADDR[1:0] ignored. ADDR < BASE_ADDRESS or index ≥ N_REGISTERS is out of range.
- Write FSM, states IDLE / HAVE_AW / HAVE_W / RESP:
  - IDLE: AWREADY=WREADY=1. Capture AW and/or W on their handshakes. Both in one cycle: commit, go to RESP. Only AW: go to HAVE_AW. Only W: go to HAVE_W.
  - HAVE_AW: AWREADY=0, WREADY=1. On W handshake: commit, go to RESP.
  - HAVE_W: WREADY=0, AWREADY=1. On AW handshake: commit, go to RESP.
  - RESP: both readies 0, BVALID=1. BRESP is held stable until BREADY; on the B handshake go to IDLE.
- Commit, in range and RW: byte lane k of register i takes WDATA[8k+7:8k] only if WSTRB[k]=1. `register_write_pulse[i]` fires even if WSTRB=0. BRESP=OKAY (2'b00).
- Commit, RO register or out of range: no register change, no pulse, BRESP=SLVERR (2'b10).
- Read FSM, states IDLE / RESP:
  - IDLE: ARREADY=1. On the AR handshake, register RDATA and RRESP and go to RESP.
  - RESP: ARREADY=0, RVALID=1. RDATA and RRESP are held until RREADY.
  - RDATA source: RW register value, `input_registers[i]` for RO registers, or 0 with SLVERR when out of range.
- Read and write channels are fully independent and may be active in the same cycle.
- AWPROT, ARPROT: ignored.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0.
  - BRESP, RRESP = 2'b00; RDATA = 0.
  - `output_registers` = 0; `register_write_pulse` = 0.
  - Readies rise on the first rising edge after reset deassertion.
- Write latency: the commit edge is the edge of the later of the AW and W handshakes.
  - After the commit edge: `output_registers` updated, `register_write_pulse` high for exactly one cycle, BVALID high.
- After the B handshake edge: BVALID low, AWREADY and WREADY high. Maximum write throughput is one write per 2 cycles.
- Read latency: RVALID is high in the cycle after the AR handshake edge. After the R handshake edge: RVALID low, ARREADY high. Maximum read throughput is one read per 2 cycles.
- Read of a register sampled on the same edge as a write commit to it: returns the pre-write value.
- RO register reads sample `input_registers` at the AR handshake edge.
- Reset mid-transaction: all in-flight state is discarded immediately (asynchronous); the pending BVALID/RVALID are dropped and no response is ever issued.
- Holding BREADY/RREADY low indefinitely: the response is held stable; no further transactions are accepted on that channel.

## Test plan
- Reset, then AW+W to BASE+0x4, WDATA=0xDEADBEEF, WSTRB=4'hF, same cycle -> next cycle `output_registers[1]`=0xDEADBEEF, pulse[1]=1 for one cycle, BVALID=1, BRESP=00.
- AW to BASE+0x8 at cycle 0, W with WDATA=0x12345678, WSTRB=4'b0101 at cycle 3, starting from reg2=0 -> AWREADY=0 during cycles 1-3; reg2=0x00340078 after the cycle-3 edge; BVALID stays high until BREADY is asserted 5 cycles later.
- RO_MASK=8'h80, `input_registers[7]`=0xCAFE0001 -> read of BASE+0x1C returns 0xCAFE0001 OKAY; a write there returns SLVERR with no pulse and no change.
- Read and write at BASE+0x20 with N_REGISTERS=8 -> RDATA=0 with RRESP=10, and BRESP=10 with no pulse.
- Write commit to reg0 (0x0→0x55) on the same edge as an AR to reg0 -> RDATA=0x0; a subsequent read returns 0x55.
- Assert reset while BVALID=1 and RVALID=1 -> both drop immediately, registers return to 0, readies return to 1 one edge after release.

Source files
------------

// File: rtl/axil_register_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite
//  Brief    : AXI4-Lite bus bundle with master and slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_lite #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axil_register_responder.sv
`default_nettype none
// ============================================================================
//  Module   : axil_register_responder
//  Brief    : AXI-Lite slave exposing a bank of 32-bit RW control and RO
//             status registers, with a per-register write pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module axil_register_responder #(
    parameter int                     N_REGISTERS  = 8,
    parameter logic [31:0]            BASE_ADDRESS = 32'h0,
    parameter logic [N_REGISTERS-1:0] RO_MASK      = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    axi_lite.slave                        axil,
    input  logic [N_REGISTERS-1:0][31:0]  input_registers,
    output logic [N_REGISTERS-1:0][31:0]  output_registers,
    output logic [N_REGISTERS-1:0]        register_write_pulse
);

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    function automatic logic f_in_range(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - BASE_ADDRESS;
        return (addr >= BASE_ADDRESS) && ((offset >> 2) < 32'(N_REGISTERS));
    endfunction

    function automatic logic [29:0] f_index(input logic [31:0] addr);
        return 30'((addr - BASE_ADDRESS) >> 2);
    endfunction

    // Readies stay low until the first edge after reset release.
    logic                         r_ready_en;

    wr_state_t                    r_wr_state;
    wr_state_t                    w_wr_state_next;
    rd_state_t                    r_rd_state;
    rd_state_t                    w_rd_state_next;

    logic                         w_awready;
    logic                         w_wready;
    logic                         w_arready;
    logic                         w_aw_hs;
    logic                         w_w_hs;
    logic                         w_ar_hs;
    logic                         w_commit;

    logic [31:0]                  r_aw_addr;
    logic [31:0]                  r_wdata;
    logic [3:0]                   r_wstrb;
    logic [31:0]                  w_commit_addr;
    logic [31:0]                  w_commit_data;
    logic [3:0]                   w_commit_strb;
    logic                         w_commit_in_range;
    logic [29:0]                  w_commit_idx;
    logic [N_REGISTERS-1:0]       w_commit_sel;

    logic [N_REGISTERS-1:0][31:0] r_regs;
    logic [N_REGISTERS-1:0][31:0] w_read_word;
    logic [N_REGISTERS-1:0]       r_pulse;
    logic [1:0]                   r_bresp;

    logic [31:0]                  w_rd_data;
    logic [1:0]                   w_rd_resp;
    logic [31:0]                  r_rdata;
    logic [1:0]                   r_rresp;

    logic                         w_unused;
    assign w_unused = ^{axil.awprot, axil.arprot};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    assign w_awready = r_ready_en && (r_wr_state == WR_IDLE || r_wr_state == WR_HAVE_W);
    assign w_wready  = r_ready_en && (r_wr_state == WR_IDLE || r_wr_state == WR_HAVE_AW);
    assign w_aw_hs   = axil.awvalid && w_awready;
    assign w_w_hs    = axil.wvalid && w_wready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_state <= WR_IDLE;
        end else begin
            r_wr_state <= w_wr_state_next;
        end
    end

    always_comb begin
        w_wr_state_next = r_wr_state;
        w_commit        = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit        = 1'b1;
                    w_wr_state_next = WR_RESP;
                end else if (w_aw_hs) begin
                    w_wr_state_next = WR_HAVE_AW;
                end else if (w_w_hs) begin
                    w_wr_state_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_w_hs) begin
                    w_commit        = 1'b1;
                    w_wr_state_next = WR_RESP;
                end
            end
            WR_HAVE_W: begin
                if (w_aw_hs) begin
                    w_commit        = 1'b1;
                    w_wr_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axil.bready) begin
                    w_wr_state_next = WR_IDLE;
                end
            end
            default: w_wr_state_next = WR_IDLE;
        endcase
    end

    // The commit uses whichever half arrived earlier from the capture
    // registers and the half arriving now straight from the bus.
    assign w_commit_addr     = (r_wr_state == WR_HAVE_AW) ? r_aw_addr : axil.awaddr;
    assign w_commit_data     = (r_wr_state == WR_HAVE_W)  ? r_wdata   : axil.wdata;
    assign w_commit_strb     = (r_wr_state == WR_HAVE_W)  ? r_wstrb   : axil.wstrb;
    assign w_commit_in_range = f_in_range(w_commit_addr);
    assign w_commit_idx      = f_index(w_commit_addr);

    always_comb begin
        w_commit_sel = '0;
        for (int i = 0; i < N_REGISTERS; i++) begin
            if (w_commit && w_commit_in_range && !RO_MASK[i] && (w_commit_idx == 30'(i))) begin
                w_commit_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_aw_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= c_resp_okay;
        end else begin
            if (w_aw_hs) begin
                r_aw_addr <= axil.awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= axil.wdata;
                r_wstrb <= axil.wstrb;
            end
            if (w_commit) begin
                r_bresp <= (|w_commit_sel) ? c_resp_okay : c_resp_slverr;
            end
        end
    end

    // Register bank; the pulse fires on any accepted commit, even with no strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_regs  <= '0;
            r_pulse <= '0;
        end else begin
            r_pulse <= w_commit_sel;
            for (int i = 0; i < N_REGISTERS; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (w_commit_sel[i] && w_commit_strb[k]) begin
                        r_regs[i][8*k +: 8] <= w_commit_data[8*k +: 8];
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_REGISTERS; gi++) begin : g_map
        assign output_registers[gi] = RO_MASK[gi] ? 32'd0 : r_regs[gi];
        assign w_read_word[gi]      = RO_MASK[gi] ? input_registers[gi] : r_regs[gi];
    end

    assign register_write_pulse = r_pulse;
    assign axil.awready         = w_awready;
    assign axil.wready          = w_wready;
    assign axil.bvalid          = (r_wr_state == WR_RESP);
    assign axil.bresp           = r_bresp;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    assign w_arready = r_ready_en && (r_rd_state == RD_IDLE);
    assign w_ar_hs   = axil.arvalid && w_arready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_state_next;
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (axil.rready) begin
                    w_rd_state_next = RD_IDLE;
                end
            end
            default: w_rd_state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = c_resp_slverr;
        if (f_in_range(axil.araddr)) begin
            w_rd_resp = c_resp_okay;
            for (int i = 0; i < N_REGISTERS; i++) begin
                if (f_index(axil.araddr) == 30'(i)) begin
                    w_rd_data = w_read_word[i];
                end
            end
        end
    end

    // Sampled on the handshake edge, so a same-edge write is not yet visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
            r_rresp <= c_resp_okay;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

    assign axil.arready = w_arready;
    assign axil.rvalid  = (r_rd_state == RD_RESP);
    assign axil.rdata   = r_rdata;
    assign axil.rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axil_register_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_register_responder
//  Brief    : Self-checking bench for axil_register_responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_register_responder;

    localparam int          N     = 8;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam logic [N-1:0] RO   = 8'h80;
    localparam int          BOUND = 50;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0][31:0] input_registers;
    logic [N-1:0][31:0] output_registers;
    logic [N-1:0]      register_write_pulse;

    axi_lite #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) axil ();

    axil_register_responder #(
        .N_REGISTERS (N),
        .BASE_ADDRESS(BASE),
        .RO_MASK     (RO)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .axil                (axil),
        .input_registers     (input_registers),
        .output_registers    (output_registers),
        .register_write_pulse(register_write_pulse)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [N];
    logic [N-1:0] ro_mask = RO;

    logic [1:0]   wr_bresp;
    logic [N-1:0] wr_pulse1, wr_pulse2;
    logic         wr_bvalid_ok, wr_hold_ok, wr_after_ok, wr_timeout;
    logic [31:0]  rd_data;
    logic [1:0]   rd_resp;
    logic         rd_valid_ok, rd_hold_ok, rd_after_ok, rd_timeout;

    function automatic logic [N-1:0][31:0] exp_outputs();
        logic [N-1:0][31:0] v;
        for (int i = 0; i < N; i++) v[i] = ro_mask[i] ? 32'd0 : model[i];
        return v;
    endfunction

    // Drives one write; AW/W appear at cycle aw_at/w_at, BREADY waits b_lag cycles.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int aw_at, input int w_at, input int b_lag);
        int   cyc = 0;
        logic aw_done = 1'b0, w_done = 1'b0, hs_aw, hs_w;
        wr_timeout = 1'b0; wr_hold_ok = 1'b1;
        axil.awaddr = addr; axil.wdata = data; axil.wstrb = strb;
        while (!(aw_done && w_done)) begin
            if (cyc >= BOUND) begin wr_timeout = 1'b1; break; end
            axil.awvalid = !aw_done && (cyc >= aw_at);
            axil.wvalid  = !w_done && (cyc >= w_at);
            hs_aw = axil.awvalid && axil.awready;
            hs_w  = axil.wvalid && axil.wready;
            if ((aw_done && !w_done && axil.awready) || (w_done && !aw_done && axil.wready)) wr_hold_ok = 1'b0;
            @(posedge clock); #1;
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            cyc++;
        end
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        if (wr_timeout) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout: handshake incomplete after %0d cycles, required completion", BOUND);
            wr_bvalid_ok = 1'b0; wr_after_ok = 1'b0;
            return;
        end
        wr_bvalid_ok = axil.bvalid; wr_bresp = axil.bresp;
        wr_pulse1 = register_write_pulse; wr_pulse2 = '0;
        for (int k = 0; k < b_lag; k++) begin
            @(posedge clock); #1;
            if (k == 0) wr_pulse2 = register_write_pulse;
            if (!axil.bvalid || axil.bresp !== wr_bresp || axil.awready || axil.wready) wr_hold_ok = 1'b0;
        end
        axil.bready = 1'b1;
        @(posedge clock); #1;
        axil.bready = 1'b0;
        if (b_lag == 0) wr_pulse2 = register_write_pulse;
        wr_after_ok = !axil.bvalid && axil.awready && axil.wready;
    endtask

    task automatic rd(input logic [31:0] addr, input int r_lag);
        int   cyc = 0;
        logic done = 1'b0, hs;
        rd_timeout = 1'b0; rd_hold_ok = 1'b1;
        axil.araddr = addr; axil.arvalid = 1'b1;
        while (!done) begin
            if (cyc >= BOUND) begin rd_timeout = 1'b1; break; end
            hs = axil.arready;
            @(posedge clock); #1;
            done = hs;
            cyc++;
        end
        axil.arvalid = 1'b0;
        if (rd_timeout) begin
            n_checks++; n_fail++;
            $display("FAIL read_timeout: handshake incomplete after %0d cycles, required completion", BOUND);
            rd_valid_ok = 1'b0; rd_after_ok = 1'b0;
            return;
        end
        rd_valid_ok = axil.rvalid; rd_data = axil.rdata; rd_resp = axil.rresp;
        for (int k = 0; k < r_lag; k++) begin
            @(posedge clock); #1;
            if (!axil.rvalid || axil.rdata !== rd_data || axil.rresp !== rd_resp || axil.arready) rd_hold_ok = 1'b0;
        end
        axil.rready = 1'b1;
        @(posedge clock); #1;
        axil.rready = 1'b0;
        rd_after_ok = !axil.rvalid && axil.arready;
    endtask

    task automatic test_reset();
        axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
        axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
        axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
        for (int i = 0; i < N; i++) input_registers[i] = $urandom();
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid} !== 5'b0)
            begin n_fail++; $display("FAIL reset_handshake: got %b expected 00000", {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid}); end
        n_checks++;
        if ({axil.bresp, axil.rresp, axil.rdata} !== 36'd0)
            begin n_fail++; $display("FAIL reset_resp: got %h expected 0", {axil.bresp, axil.rresp, axil.rdata}); end
        n_checks++;
        if (output_registers !== '0 || register_write_pulse !== '0)
            begin n_fail++; $display("FAIL reset_outputs: got %h/%b expected 0/0", output_registers, register_write_pulse); end
        @(negedge clock); reset = 1'b1; #1;
        n_checks++;
        if ({axil.awready, axil.wready, axil.arready} !== 3'b000)
            begin n_fail++; $display("FAIL ready_before_edge: got %b expected 000", {axil.awready, axil.wready, axil.arready}); end
        @(posedge clock); #1;
        n_checks++;
        if ({axil.awready, axil.wready, axil.arready} !== 3'b111)
            begin n_fail++; $display("FAIL ready_after_edge: got %b expected 111", {axil.awready, axil.wready, axil.arready}); end
        for (int i = 0; i < N; i++) model[i] = '0;
    endtask

    task automatic test_read_during_write();
        fork
            wr(BASE, 32'h55, 4'hF, 0, 0, 0);
            rd(BASE, 0);
        join
        model[0] = 32'h55;
        n_checks++;
        if (rd_data !== 32'h0 || rd_resp !== 2'b00)
            begin n_fail++; $display("FAIL same_edge_read: got %h/%b expected 00000000/00", rd_data, rd_resp); end
        n_checks++;
        if (wr_bresp !== 2'b00 || wr_pulse1 !== 8'h01)
            begin n_fail++; $display("FAIL same_edge_write: got %b/%b expected 00/00000001", wr_bresp, wr_pulse1); end
        rd(BASE, 0);
        n_checks++;
        if (rd_data !== 32'h55)
            begin n_fail++; $display("FAIL read_after_write: got %h expected 00000055", rd_data); end
    endtask

    task automatic test_write_same_cycle();
        wr(BASE + 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        model[1] = 32'hDEADBEEF;
        n_checks++;
        if (output_registers[1] !== 32'hDEADBEEF || wr_bresp !== 2'b00 || !wr_bvalid_ok)
            begin n_fail++; $display("FAIL aw_w_together: got %h/%b/%b expected deadbeef/00/1", output_registers[1], wr_bresp, wr_bvalid_ok); end
        n_checks++;
        if (wr_pulse1 !== 8'h02 || wr_pulse2 !== 8'h00)
            begin n_fail++; $display("FAIL pulse_one_cycle: got %b,%b expected 00000010,00000000", wr_pulse1, wr_pulse2); end
        n_checks++;
        if (!wr_after_ok)
            begin n_fail++; $display("FAIL after_b: got %b expected 1", wr_after_ok); end
    endtask

    task automatic test_write_aw_first();
        wr(BASE + 32'h8, 32'h12345678, 4'b0101, 0, 3, 5);
        model[2] = 32'h00340078;
        n_checks++;
        if (output_registers[2] !== 32'h00340078)
            begin n_fail++; $display("FAIL strobe_merge: got %h expected 00340078", output_registers[2]); end
        n_checks++;
        if (!wr_hold_ok || !wr_bvalid_ok || !wr_after_ok || wr_pulse1 !== 8'h04)
            begin n_fail++; $display("FAIL aw_first_protocol: got hold=%b bvalid=%b after=%b pulse=%b expected 1/1/1/00000100", wr_hold_ok, wr_bvalid_ok, wr_after_ok, wr_pulse1); end
    endtask

    task automatic test_write_w_first();
        wr(BASE + 32'hC, 32'hA5B6C7D8, 4'b1010, 2, 0, 1);
        model[3] = {8'hA5, 8'h00, 8'hC7, 8'h00};
        n_checks++;
        if (output_registers !== exp_outputs() || !wr_hold_ok || wr_bresp !== 2'b00)
            begin n_fail++; $display("FAIL w_first: got %h hold=%b resp=%b expected %h 1 00", output_registers, wr_hold_ok, wr_bresp, exp_outputs()); end
        wr(BASE + 32'h4, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
        n_checks++;
        if (wr_pulse1 !== 8'h02 || wr_bresp !== 2'b00 || output_registers !== exp_outputs())
            begin n_fail++; $display("FAIL zero_strobe: got pulse=%b resp=%b regs=%h expected 00000010 00 %h", wr_pulse1, wr_bresp, output_registers, exp_outputs()); end
    endtask

    task automatic test_ro_register();
        input_registers[7] = 32'hCAFE0001;
        rd(BASE + 32'h1C, 2);
        n_checks++;
        if (rd_data !== 32'hCAFE0001 || rd_resp !== 2'b00 || !rd_hold_ok || !rd_valid_ok || !rd_after_ok)
            begin n_fail++; $display("FAIL ro_read: got %h/%b hold=%b expected cafe0001/00 1", rd_data, rd_resp, rd_hold_ok); end
        wr(BASE + 32'h1C, 32'h12121212, 4'hF, 0, 1, 0);
        n_checks++;
        if (wr_bresp !== 2'b10 || wr_pulse1 !== 8'h00 || output_registers !== exp_outputs())
            begin n_fail++; $display("FAIL ro_write: got %b/%b/%h expected 10/00000000/%h", wr_bresp, wr_pulse1, output_registers, exp_outputs()); end
    endtask

    task automatic test_out_of_range();
        rd(BASE + 32'h20, 0);
        n_checks++;
        if (rd_data !== 32'h0 || rd_resp !== 2'b10)
            begin n_fail++; $display("FAIL oor_read: got %h/%b expected 00000000/10", rd_data, rd_resp); end
        wr(BASE + 32'h20, 32'h77777777, 4'hF, 1, 0, 0);
        n_checks++;
        if (wr_bresp !== 2'b10 || wr_pulse1 !== 8'h00 || output_registers !== exp_outputs())
            begin n_fail++; $display("FAIL oor_write: got %b/%b/%h expected 10/00000000/%h", wr_bresp, wr_pulse1, output_registers, exp_outputs()); end
        rd(BASE - 32'h4, 0);
        n_checks++;
        if (rd_data !== 32'h0 || rd_resp !== 2'b10)
            begin n_fail++; $display("FAIL below_base_read: got %h/%b expected 00000000/10", rd_data, rd_resp); end
    endtask

    task automatic test_random();
        int           sel;
        logic [31:0]  addr, data, exp_data;
        logic [3:0]   strb;
        logic         exp_ok;
        logic [N-1:0] exp_pulse;
        for (int t = 0; t < 40; t++) begin
            sel  = int'($urandom_range(0, 10));
            addr = (sel == 10) ? BASE - 32'd4 : BASE + 32'(sel) * 32'd4 + 32'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) input_registers[i] = $urandom();
            exp_ok = (sel < N) ? !ro_mask[sel[2:0]] : 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom();
                strb = 4'($urandom_range(0, 15));
                wr(addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
                exp_pulse = '0;
                if (exp_ok) begin
                    exp_pulse[sel[2:0]] = 1'b1;
                    for (int k = 0; k < 4; k++) if (strb[k]) model[sel][8*k +: 8] = data[8*k +: 8];
                end
                n_checks++;
                if (wr_bresp !== (exp_ok ? 2'b00 : 2'b10))
                    begin n_fail++; $display("FAIL rand_bresp[%0d]: got %b expected %b", t, wr_bresp, exp_ok ? 2'b00 : 2'b10); end
                n_checks++;
                if (wr_pulse1 !== exp_pulse || wr_pulse2 !== '0)
                    begin n_fail++; $display("FAIL rand_pulse[%0d]: got %b,%b expected %b,0", t, wr_pulse1, wr_pulse2, exp_pulse); end
                n_checks++;
                if (output_registers !== exp_outputs())
                    begin n_fail++; $display("FAIL rand_regs[%0d]: got %h expected %h", t, output_registers, exp_outputs()); end
                n_checks++;
                if ({wr_bvalid_ok, wr_hold_ok, wr_after_ok} !== 3'b111)
                    begin n_fail++; $display("FAIL rand_wr_protocol[%0d]: got %b expected 111", t, {wr_bvalid_ok, wr_hold_ok, wr_after_ok}); end
            end else begin
                rd(addr, int'($urandom_range(0, 2)));
                if (sel >= N)               exp_data = 32'h0;
                else if (ro_mask[sel[2:0]]) exp_data = input_registers[sel];
                else                        exp_data = model[sel];
                n_checks++;
                if (rd_data !== exp_data || rd_resp !== ((sel < N) ? 2'b00 : 2'b10))
                    begin n_fail++; $display("FAIL rand_read[%0d]: got %h/%b expected %h/%b", t, rd_data, rd_resp, exp_data, (sel < N) ? 2'b00 : 2'b10); end
                n_checks++;
                if ({rd_valid_ok, rd_hold_ok, rd_after_ok} !== 3'b111)
                    begin n_fail++; $display("FAIL rand_rd_protocol[%0d]: got %b expected 111", t, {rd_valid_ok, rd_hold_ok, rd_after_ok}); end
            end
        end
    endtask

    task automatic test_reset_mid_transaction();
        axil.awaddr = BASE + 32'hC; axil.wdata = 32'h0BADF00D; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        axil.araddr = BASE + 32'h4; axil.arvalid = 1'b1;
        @(posedge clock); #1;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
        n_checks++;
        if ({axil.bvalid, axil.rvalid} !== 2'b11 || output_registers[3] !== 32'h0BADF00D)
            begin n_fail++; $display("FAIL midreset_setup: got %b/%h expected 11/0badf00d", {axil.bvalid, axil.rvalid}, output_registers[3]); end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({axil.bvalid, axil.rvalid, axil.awready, axil.wready, axil.arready} !== 5'b0)
            begin n_fail++; $display("FAIL midreset_drop: got %b expected 00000", {axil.bvalid, axil.rvalid, axil.awready, axil.wready, axil.arready}); end
        n_checks++;
        if (output_registers !== '0 || register_write_pulse !== '0)
            begin n_fail++; $display("FAIL midreset_regs: got %h/%b expected 0/0", output_registers, register_write_pulse); end
        @(negedge clock); reset = 1'b1; #1;
        n_checks++;
        if ({axil.awready, axil.wready, axil.arready} !== 3'b000)
            begin n_fail++; $display("FAIL midreset_release: got %b expected 000", {axil.awready, axil.wready, axil.arready}); end
        @(posedge clock); #1;
        n_checks++;
        if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid} !== 5'b11100)
            begin n_fail++; $display("FAIL midreset_recover: got %b expected 11100", {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid}); end
        for (int i = 0; i < N; i++) model[i] = '0;
        rd(BASE + 32'hC, 0);
        n_checks++;
        if (rd_data !== 32'h0 || rd_resp !== 2'b00)
            begin n_fail++; $display("FAIL midreset_readback: got %h/%b expected 00000000/00", rd_data, rd_resp); end
    endtask

    initial begin
        test_reset();
        test_read_during_write();
        test_write_same_cycle();
        test_write_aw_first();
        test_write_w_first();
        test_ro_register();
        test_out_of_range();
        test_random();
        test_reset_mid_transaction();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
